resp_framer: RTL and testbench

RESP_FRAMER -- requirements
Module: resp_framer

---
 rtl/resp_framer.sv | 150 +++++++++++++++
 tb/tb_resp_framer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/resp_framer.sv
// Response packet framer: takes one descriptor (opcode, up to 8 payload bytes,
// length) and serializes it as opcode, 0x00, LEN lsb, LEN msb, payload bytes.
// LEN counts the 4 header bytes plus the clamped payload length.
module resp_framer #(
  parameter int MAX_PAYLOAD_P = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  opcode_i,
  input  logic [63:0] data_i,
  input  logic [3:0]  len_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o
);

  localparam logic [3:0] MaxLen = 4'(MAX_PAYLOAD_P);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPCODE,
    S_RESERVED,
    S_LSB,
    S_MSB,
    S_PAYLOAD
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] payload_q, payload_d;
  logic [3:0]  len_q, len_d;

  logic [3:0]  len_clamp;
  logic [15:0] len_field;
  logic [2:0]  nxt_idx;
  logic        hs;
  logic [7:0]  pay_byte [8];

  // Little-endian byte view of the captured payload word.
  for (genvar gi = 0; gi < 8; gi++) begin : g_bytes
    assign pay_byte[gi] = payload_q[8*gi +: 8];
  end

  assign len_clamp = (len_i > MaxLen) ? MaxLen : len_i;
  assign len_field = 16'd4 + {12'd0, len_q};
  assign nxt_idx   = cnt_q[2:0] + 3'd1;
  assign hs        = valid_q & ready_i;

  assign ready_o = (state_q == S_IDLE);
  assign busy_o  = (state_q != S_IDLE);
  assign data_o  = data_q;
  assign valid_o = valid_q;

  // State and output registers; reset aborts any packet in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      cnt_q     <= 4'd0;
      payload_q <= 64'd0;
      len_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      payload_q <= payload_d;
      len_q     <= len_d;
    end
  end

  // Next-state logic: each state advances on a byte handshake and preloads
  // the following byte, so data_o/valid_o always come straight from flops.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    payload_d = payload_q;
    len_d     = len_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          payload_d = data_i;
          len_d     = len_clamp;
          data_d    = opcode_i;
          valid_d   = 1'b1;
          state_d   = S_OPCODE;
        end
      end
      S_OPCODE: begin
        if (hs) begin
          data_d  = 8'h00;
          state_d = S_RESERVED;
        end
      end
      S_RESERVED: begin
        if (hs) begin
          data_d  = len_field[7:0];
          state_d = S_LSB;
        end
      end
      S_LSB: begin
        if (hs) begin
          data_d  = len_field[15:8];
          state_d = S_MSB;
        end
      end
      S_MSB: begin
        if (hs) begin
          if (len_q == 4'd0) begin
            data_d  = 8'h00;
            valid_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            data_d  = pay_byte[0];
            cnt_d   = 4'd0;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (hs) begin
          if (cnt_q == len_q - 4'd1) begin
            data_d  = 8'h00;
            valid_d = 1'b0;
            cnt_d   = 4'd0;
            state_d = S_IDLE;
          end else begin
            data_d = pay_byte[nxt_idx];
            cnt_d  = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        data_d  = 8'h00;
        valid_d = 1'b0;
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_resp_framer.sv
// Self-checking bench for resp_framer: directed packets plus randomized ones,
// each compared against a byte-queue model built from the packet format rules.
module tb_resp_framer;

  localparam logic [7:0] OP_ECHO = 8'h01;
  localparam logic [7:0] OP_ADD  = 8'h02;
  localparam logic [7:0] OP_MUL  = 8'h03;
  localparam logic [7:0] OP_DIV  = 8'h04;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  opcode_i;
  logic [63:0] data_i;
  logic [3:0]  len_i;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic        busy_o;

  int tests = 0;
  int fails = 0;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  resp_framer #(.MAX_PAYLOAD_P(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode_i (opcode_i),
    .data_i   (data_i),
    .len_i    (len_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge. Presents a descriptor, waits for acceptance,
  // then drains the packet with the chosen ready_i pattern
  // (0: always high, 1: fixed toggle pattern, 2: random).
  // abort_at >= 0 pulses reset when that many bytes have been transferred.
  // chain keeps valid_i high with a second descriptor after acceptance.
  task automatic run_packet(input string name, input logic [7:0] op, input logic [63:0] d,
                            input logic [3:0] len, input int mode, input int abort_at,
                            input bit expect_immediate, input bit chain,
                            input logic [7:0] op2, input logic [63:0] d2, input logic [3:0] len2);
    logic [7:0]  q[$];
    logic [15:0] lenf;
    logic [7:0]  prev_data;
    int clamped, waited, hs_count, cyc, total;
    bit prev_stall;

    clamped = (len > 4'd8) ? 8 : int'(len);
    lenf = 16'(4 + clamped);
    q = {op, 8'h00, lenf[7:0], lenf[15:8]};
    for (int i = 0; i < clamped; i++) q.push_back(d[8*i +: 8]);
    total = q.size();

    opcode_i = op; data_i = d; len_i = len; valid_i = 1'b1;
    waited = 0;
    while (!ready_o && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_accept_ready"}, 32'(ready_o), 1);
    if (expect_immediate) check({name, "_immediate_accept"}, 32'(waited), 0);
    @(negedge clk);
    if (chain) begin
      opcode_i = op2; data_i = d2; len_i = len2; valid_i = 1'b1;
    end else begin
      valid_i = 1'b0;
      opcode_i = 8'($urandom);
      data_i = {$urandom, $urandom};
      len_i = 4'($urandom);
    end
    check({name, "_latency1_valid"}, 32'(valid_o), 1);
    check({name, "_busy"}, 32'(busy_o), 1);

    prev_stall = 1'b0; prev_data = 8'h00; hs_count = 0; cyc = 0;
    while (q.size() > 0 && cyc < 500) begin
      if (abort_at >= 0 && hs_count == abort_at) begin
        check({name, "_byte_before_abort"}, 32'(data_o), 32'(q[0]));
        rst_n = 1'b0; ready_i = 1'b1;
        @(negedge clk);
        check({name, "_abort_valid"}, 32'(valid_o), 0);
        check({name, "_abort_busy"}, 32'(busy_o), 0);
        check({name, "_abort_data"}, 32'(data_o), 0);
        rst_n = 1'b1; valid_i = 1'b0;
        @(negedge clk);
        check({name, "_ready_after_release"}, 32'(ready_o), 1);
        check({name, "_no_bytes_after_abort"}, 32'(valid_o), 0);
        return;
      end
      if (prev_stall) check({name, "_stall_data"}, 32'(data_o), 32'(prev_data));
      check({name, "_valid_inflight"}, 32'(valid_o), 1);
      check({name, "_ready_low_inflight"}, 32'(ready_o), 0);
      case (mode)
        0:       ready_i = 1'b1;
        1:       ready_i = pat[cyc % 6];
        default: ready_i = 1'($urandom);
      endcase
      if (valid_o && ready_i) begin
        check({name, "_byte"}, 32'(data_o), 32'(q.pop_front()));
        hs_count++;
      end
      prev_stall = valid_o && !ready_i;
      prev_data = data_o;
      cyc++;
      @(negedge clk);
    end
    check({name, "_no_timeout"}, 32'(cyc < 500), 1);
    check({name, "_byte_count"}, 32'(hs_count), 32'(total));
    if (mode == 0) check({name, "_cycles"}, 32'(cyc), 32'(total));
    check({name, "_end_valid"}, 32'(valid_o), 0);
    check({name, "_end_ready"}, 32'(ready_o), 1);
    check({name, "_end_busy"}, 32'(busy_o), 0);
  endtask

  initial begin
    rst_n = 1'b0; opcode_i = 8'h00; data_i = 64'd0; len_i = 4'd0;
    valid_i = 1'b0; ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(valid_o), 0);
    check("reset_data", 32'(data_o), 0);
    check("reset_busy", 32'(busy_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(ready_o), 1);

    run_packet("add4", OP_ADD, 64'h0000_0000_0000_0007, 4'd4, 0, -1, 1'b1, 1'b0, 8'h0, 64'd0, 4'd0);
    run_packet("echo0", OP_ECHO, 64'hDEAD_BEEF_0BAD_F00D, 4'd0, 0, -1, 1'b1, 1'b0, 8'h0, 64'd0, 4'd0);
    run_packet("len8_toggle", OP_MUL, 64'h8877_6655_4433_2211, 4'd8, 1, -1, 1'b1, 1'b0, 8'h0, 64'd0, 4'd0);
    run_packet("len15_clamp", OP_DIV, 64'hF0E1_D2C3_B4A5_9687, 4'd15, 2, -1, 1'b1, 1'b0, 8'h0, 64'd0, 4'd0);
    run_packet("abort", OP_ADD, 64'h0102_0304_0506_0708, 4'd8, 0, 6, 1'b1, 1'b0, 8'h0, 64'd0, 4'd0);
    run_packet("after_abort", OP_MUL, 64'h1122_3344_5566_7788, 4'd5, 2, -1, 1'b1, 1'b0, 8'h0, 64'd0, 4'd0);
    run_packet("chain_first", OP_DIV, 64'h0000_0000_00AA_BBCC, 4'd3, 0, -1, 1'b1, 1'b1,
               OP_ECHO, 64'h0000_0000_0000_5A5A, 4'd2);
    run_packet("chain_second", OP_ECHO, 64'h0000_0000_0000_5A5A, 4'd2, 0, -1, 1'b1, 1'b0, 8'h0, 64'd0, 4'd0);

    for (int n = 0; n < 20; n++) begin
      run_packet("rand", 8'($urandom), {$urandom, $urandom}, 4'($urandom_range(0, 15)), 2, -1,
                 1'b1, 1'b0, 8'h0, 64'd0, 4'd0);
      $display("[TB] random packet %0d done, %0d tests so far", n, tests);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
